// File: rtl/exc_commit_pkg.sv
// exc_commit_pkg: exception flag layout (highest priority first), ExcCodes, vectors and the commit FSM state type
package exc_commit_pkg;
  typedef struct packed {
    logic interrupt;
    logic fetch_adel;
    logic fetch_tlb_refill;
    logic fetch_tlb_invalid;
    logic ri;
    logic ov;
    logic syscall;
    logic brk;
    logic eret;
    logic data_adel;
    logic data_ades;
    logic data_tlbl_refill;
    logic data_tlbl_invalid;
    logic data_tlbs_refill;
    logic data_tlbs_invalid;
    logic tlb_mod;
  } ExceptinPipeType;
  localparam int EXC_W = $bits(ExceptinPipeType);
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [31:0] VEC_REFILL  = 32'hBFC0_0200;
  localparam logic [31:0] VEC_GENERAL = 32'hBFC0_0380;
  typedef enum logic {IDLE, REDIRECT} state_t;
  function automatic logic [4:0] exc_code(ExceptinPipeType e);
    return e.interrupt ? EXC_INT :
           (e.fetch_adel | e.data_adel) ? EXC_ADEL :
           (e.fetch_tlb_refill | e.fetch_tlb_invalid | e.data_tlbl_refill | e.data_tlbl_invalid) ? EXC_TLBL :
           e.ri ? EXC_RI :
           e.ov ? EXC_OV :
           e.syscall ? EXC_SYS :
           e.brk ? EXC_BP :
           e.data_ades ? EXC_ADES :
           (e.data_tlbs_refill | e.data_tlbs_invalid) ? EXC_TLBS :
           e.tlb_mod ? EXC_MOD : 5'd0;
  endfunction
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: keeps only the highest-priority (most significant) exception flag and returns its ExcCode; flags in, win/code out
module exc_prio_enc import exc_commit_pkg::*; (
  input  ExceptinPipeType flags,
  output ExceptinPipeType win,
  output logic [4:0]      code
);
  logic [EXC_W-1:0] w;
  always_comb begin
    w = '0;
    for (int i = 0; i < EXC_W; i++) if (flags[i]) w = EXC_W'(1) << i;
  end
  assign win = w;
  assign code = exc_code(win);
endmodule

// File: rtl/exc_commit.sv
// exc_commit: MEM->WB exception commit with interrupt sync, prioritisation, flush and fetch redirect handshake (clk, active-low sync rst, CP0 in, MEM in, WB/flush/redirect out)
module exc_commit import exc_commit_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      Interrupt,
  input  logic [31:0]     CP0_Status,
  input  logic [31:0]     CP0_Cause,
  input  logic [31:0]     CP0_EPC,
  input  logic            MEM_Valid,
  input  ExceptinPipeType MEM_ExceptType,
  input  logic [31:0]     MEM_PC,
  input  logic [31:0]     MEM_ALUOut,
  input  logic            MEM_IsInDelaySlot,
  output ExceptinPipeType WB_ExceptType,
  output logic [31:0]     WB_PC,
  output logic [31:0]     WB_ALUOut,
  output logic            WB_IsInDelaySlot,
  output logic [4:0]      WB_ExcCode,
  output logic            Flush_All,
  output logic            Redirect_Valid,
  output logic [31:0]     Redirect_PC,
  input  logic            Redirect_Ready
);
  state_t state, state_d;
  logic [5:0] int_s1, int_s2;
  logic [7:0] ip;
  logic int_pending, take, refill;
  logic [4:0] code;
  logic [31:0] target;
  ExceptinPipeType flags, win;
  logic unused;
  assign unused = ^{CP0_Status[31:16], CP0_Status[7:2], CP0_Cause[31], CP0_Cause[29:10], CP0_Cause[7:0]};
  assign ip = {int_s2[5] | CP0_Cause[30], int_s2[4:0], CP0_Cause[9:8]};
  assign int_pending = |(ip & CP0_Status[15:8]) & CP0_Status[0] & ~CP0_Status[1];
  // the interrupt slot is owned by this block, so the MEM stage's copy is replaced
  always_comb begin
    flags = MEM_ExceptType;
    flags.interrupt = int_pending;
  end
  exc_prio_enc u_enc (.flags(flags), .win(win), .code(code));
  assign take = MEM_Valid && state == IDLE && |flags;
  assign refill = win.fetch_tlb_refill | win.data_tlbl_refill | win.data_tlbs_refill;
  assign target = win.eret ? CP0_EPC : (refill && !CP0_Status[1]) ? VEC_REFILL : VEC_GENERAL;
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (take ? REDIRECT : IDLE) : (Redirect_Valid && Redirect_Ready ? IDLE : REDIRECT);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      int_s1 <= '0;
      int_s2 <= '0;
      WB_ExceptType <= '0;
      WB_PC <= '0;
      WB_ALUOut <= '0;
      WB_IsInDelaySlot <= 1'b0;
      WB_ExcCode <= '0;
      Flush_All <= 1'b0;
      Redirect_Valid <= 1'b0;
      Redirect_PC <= '0;
    end else begin
      state <= state_d;
      int_s1 <= Interrupt;
      int_s2 <= int_s1;
      WB_ExceptType <= take ? win : '0;
      if (state == IDLE) begin
        WB_PC <= MEM_PC;
        WB_ALUOut <= MEM_ALUOut;
        WB_IsInDelaySlot <= MEM_IsInDelaySlot;
        WB_ExcCode <= take ? code : '0;
      end
      Flush_All <= state_d == REDIRECT;
      Redirect_Valid <= state_d == REDIRECT;
      if (take) Redirect_PC <= target;
    end
  end
endmodule

// File: tb/tb_exc_commit.sv
// tb_exc_commit: scoreboard bench for exc_commit; expected exceptions are queued at drive time and popped on each WB pulse
module tb_exc_commit;
  import exc_commit_pkg::*;
  logic clk = 0, rst = 0;
  logic [5:0] Interrupt = '0;
  logic [31:0] CP0_Status = 32'h0000FF01, CP0_Cause = '0, CP0_EPC = '0;
  logic MEM_Valid = 0, MEM_IsInDelaySlot = 0, Redirect_Ready = 0;
  ExceptinPipeType MEM_ExceptType = '0, WB_ExceptType;
  logic [31:0] MEM_PC = '0, MEM_ALUOut = '0, WB_PC, WB_ALUOut, Redirect_PC;
  logic WB_IsInDelaySlot, Flush_All, Redirect_Valid;
  logic [4:0] WB_ExcCode;
  typedef struct {ExceptinPipeType t; logic [4:0] c; logic [31:0] pc, rpc;} exp_t;
  exp_t q[$];
  exp_t em;
  int n_tests = 0, n_fail = 0, n_seen = 0;
  ExceptinPipeType f, w;
  exc_commit dut (.clk(clk), .rst(rst), .Interrupt(Interrupt), .CP0_Status(CP0_Status), .CP0_Cause(CP0_Cause),
    .CP0_EPC(CP0_EPC), .MEM_Valid(MEM_Valid), .MEM_ExceptType(MEM_ExceptType), .MEM_PC(MEM_PC),
    .MEM_ALUOut(MEM_ALUOut), .MEM_IsInDelaySlot(MEM_IsInDelaySlot), .WB_ExceptType(WB_ExceptType),
    .WB_PC(WB_PC), .WB_ALUOut(WB_ALUOut), .WB_IsInDelaySlot(WB_IsInDelaySlot), .WB_ExcCode(WB_ExcCode),
    .Flush_All(Flush_All), .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC), .Redirect_Ready(Redirect_Ready));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst && WB_ExceptType != '0) begin
    if (q.size() == 0) chk("unexpected_exc", WB_ExceptType, 0);
    else begin
      em = q.pop_front();
      chk("sb_type", WB_ExceptType, em.t);
      chk("sb_code", WB_ExcCode, em.c);
      chk("sb_pc", WB_PC, em.pc);
      chk("sb_rpc", Redirect_PC, em.rpc);
      chk("sb_flush", Flush_All, 1);
      chk("sb_rvalid", Redirect_Valid, 1);
    end
    n_seen++;
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_seen(int t);
    for (int i = 0; i < 8 && n_seen < t; i++) @(negedge clk);
    #1;
    chk("pulse_seen", n_seen >= t, 1);
  endtask
  task automatic exc(ExceptinPipeType fl, ExceptinPipeType wn, logic [4:0] c, logic [31:0] pc, logic [31:0] rpc);
    int t;
    q.push_back('{wn, c, pc, rpc});
    t = n_seen + 1;
    MEM_Valid = 1; MEM_ExceptType = fl; MEM_PC = pc; Redirect_Ready = 1;
    step;
    MEM_Valid = 0; MEM_ExceptType = '0;
    wait_seen(t);
    step;
    chk("idle_after_rdy", Redirect_Valid, 0);
  endtask
  initial begin
    int t;
    step(2);
    chk("rst_type", WB_ExceptType, 0);
    chk("rst_pc", WB_PC, 0);
    chk("rst_flush", Flush_All, 0);
    chk("rst_rvalid", Redirect_Valid, 0);
    chk("rst_rpc", Redirect_PC, 0);
    chk("rst_code", WB_ExcCode, 0);
    rst = 1;
    step;
    // interrupt synchroniser latency
    q.push_back('{16'h8000, 5'd0, 32'h100, 32'hBFC00380});
    t = n_seen + 1;
    Interrupt = 6'b000001; MEM_Valid = 1; MEM_PC = 32'h100; Redirect_Ready = 1;
    step;
    chk("int_c1", WB_ExceptType, 0);
    step;
    chk("int_c2", WB_ExceptType, 0);
    step;
    chk("int_c3_flush", Flush_All, 1);
    MEM_Valid = 0; Interrupt = '0;
    wait_seen(t);
    step;
    chk("int_idle", Redirect_Valid, 0);
    step(3);
    // plain pass-through with no exception
    MEM_Valid = 1; MEM_PC = 32'h200; MEM_ALUOut = 32'hABC; MEM_IsInDelaySlot = 1;
    step;
    chk("nx_type", WB_ExceptType, 0);
    chk("nx_pc", WB_PC, 32'h200);
    chk("nx_alu", WB_ALUOut, 32'hABC);
    chk("nx_ds", WB_IsInDelaySlot, 1);
    chk("nx_flush", Flush_All, 0);
    MEM_Valid = 0; MEM_IsInDelaySlot = 0;
    f = '0; f.ri = 1; f.ov = 1; f.syscall = 1; w = '0; w.ri = 1;
    exc(f, w, 10, 32'h300, 32'hBFC00380);
    f = '0; f.fetch_tlb_refill = 1; w = f;
    exc(f, w, 2, 32'h310, 32'hBFC00200);
    CP0_Status = 32'h0000FF03;
    exc(f, w, 2, 32'h320, 32'hBFC00380);
    CP0_Status = 32'h0000FF01;
    f = '0; f.data_tlbs_refill = 1; f.tlb_mod = 1; w = '0; w.data_tlbs_refill = 1;
    exc(f, w, 3, 32'h330, 32'hBFC00200);
    f = '0; f.data_ades = 1; f.data_tlbl_invalid = 1; w = '0; w.data_ades = 1;
    exc(f, w, 5, 32'h340, 32'hBFC00380);
    f = '0; f.syscall = 1; f.brk = 1; w = '0; w.syscall = 1;
    exc(f, w, 8, 32'h350, 32'hBFC00380);
    f = '0; f.brk = 1; w = f;
    exc(f, w, 9, 32'h360, 32'hBFC00380);
    f = '0; f.fetch_adel = 1; f.ri = 1; w = '0; w.fetch_adel = 1;
    exc(f, w, 4, 32'h370, 32'hBFC00380);
    f = '0; f.tlb_mod = 1; w = f;
    exc(f, w, 1, 32'h380, 32'hBFC00380);
    // interrupt beats eret
    CP0_EPC = 32'h8000_1234; Interrupt = 6'b001000;
    step(3);
    f = '0; f.eret = 1; w = '0; w.interrupt = 1;
    exc(f, w, 0, 32'h390, 32'hBFC00380);
    Interrupt = '0;
    step(3);
    // timer interrupt via Cause[30] into IP7
    CP0_Status = 32'h00008001; CP0_Cause = 32'h4000_0000;
    f = '0; w = '0; w.interrupt = 1;
    exc(f, w, 0, 32'h3A0, 32'hBFC00380);
    CP0_Cause = '0; CP0_Status = 32'h0000FF01;
    // eret with stalled redirect, interrupt arriving mid-redirect
    q.push_back('{16'h0080, 5'd0, 32'h400, 32'h80001234});
    t = n_seen + 1;
    MEM_Valid = 1; MEM_ExceptType = '0; MEM_ExceptType.eret = 1; MEM_PC = 32'h400; Redirect_Ready = 0;
    step;
    MEM_Valid = 0; MEM_ExceptType = '0; Interrupt = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      chk("eret_rvalid", Redirect_Valid, 1);
      chk("eret_rpc", Redirect_PC, 32'h80001234);
      chk("eret_flush", Flush_All, 1);
      if (i > 0) chk("eret_pulse_once", WB_ExceptType, 0);
      step;
    end
    Redirect_Ready = 1;
    chk("eret_rvalid5", Redirect_Valid, 1);
    step;
    chk("eret_idle", Redirect_Valid, 0);
    wait_seen(t);
    q.push_back('{16'h8000, 5'd0, 32'h500, 32'hBFC00380});
    t = n_seen + 1;
    MEM_Valid = 1; MEM_PC = 32'h500;
    step;
    MEM_Valid = 0; Interrupt = '0;
    wait_seen(t);
    step(4);
    // reset abandons a redirect
    f = '0; f.syscall = 1; w = f;
    q.push_back('{w, 5'd8, 32'h600, 32'hBFC00380});
    t = n_seen + 1;
    MEM_Valid = 1; MEM_ExceptType = f; MEM_PC = 32'h600; Redirect_Ready = 0;
    step;
    MEM_Valid = 0; MEM_ExceptType = '0;
    wait_seen(t);
    rst = 0;
    step;
    chk("rr_flush", Flush_All, 0);
    chk("rr_rvalid", Redirect_Valid, 0);
    chk("rr_rpc", Redirect_PC, 0);
    chk("rr_pc", WB_PC, 0);
    chk("rr_type", WB_ExceptType, 0);
    chk("rr_code", WB_ExcCode, 0);
    rst = 1;
    step;
    chk("rr_stay_idle", Redirect_Valid, 0);
    // EXL masks interrupts
    CP0_Status = 32'h0000FF03; Interrupt = 6'b000001; MEM_Valid = 1; MEM_PC = 32'h700;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("exl_type", WB_ExceptType, 0);
      chk("exl_flush", Flush_All, 0);
    end
    MEM_Valid = 0; Interrupt = '0;
    step(2);
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
